wb_decode_switch: RTL

- Parametrised single-master, N-slave Wishbone classic interconnect.
- Successor to the fixed two-target switch: adds registered address decode and slave-side registering.
- Adds error response for unmapped addresses, bus-timeout watchdog, slave error pass-through and master-abort handling.
- Sits between the CPU data port and RAM/UART/peripheral slaves. Only one transaction is outstanding at any time.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_addr_decoder.sv | 35 +++
 rtl/wb_decode_switch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and default address map for the Wishbone decode switch family.
package wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    RESP_ACK,
    RESP_ERR,
    ERR
  } wb_state_t;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK  = 32'h8000_0000;
  localparam logic [31:0] UART_BASE = 32'h1000_0000;
  localparam logic [31:0] UART_MASK = 32'hF000_0000;

  // Index width that stays legal for a single-slave build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational region decoder: reports whether an address is mapped and
// which slave owns it (lowest index wins on overlap).
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = {UART_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {UART_MASK, RAM_MASK},
  localparam int IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] adr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_SLAVES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = (adr & SLAVE_MASK[gi]) == SLAVE_BASE[gi];
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_decode_switch.sv
// Single-master, N-slave Wishbone classic switch with registered decode,
// unmapped-address error, slave error pass-through, watchdog and abort.
module wb_decode_switch
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = {UART_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {UART_MASK, RAM_MASK},
  parameter logic [NUM_SLAVES-1:0] SUB_BASE = 2'b01,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         m_cyc,
  input  logic                         m_stb,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_adr,
  input  logic [SEL_W-1:0]             m_sel,
  input  logic [DATA_W-1:0]            m_dat_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_cyc,
  output logic [NUM_SLAVES-1:0]        s_stb,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_adr,
  output logic [SEL_W-1:0]             s_sel,
  output logic [DATA_W-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES-1:0]        s_err
);

  localparam int IDX_W   = idx_width(NUM_SLAVES);
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wb_state_t          state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg,   idx_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic [ADDR_W-1:0]  adr_reg,   adr_next;
  logic [SEL_W-1:0]   sel_reg,   sel_next;
  logic               we_reg,    we_next;
  logic [DATA_W-1:0]  wdat_reg,  wdat_next;
  logic [DATA_W-1:0]  rdat_reg,  rdat_next;

  logic                              dec_hit;
  logic [IDX_W-1:0]                  dec_idx;
  logic [NUM_SLAVES-1:0][DATA_W-1:0] s_rdat;

  assign s_rdat = s_dat_i;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .adr (m_adr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    wdat_next  = wdat_reg;
    rdat_next  = rdat_reg;

    unique case (state_reg)
      IDLE: begin
        if (m_cyc && m_stb) begin
          if (dec_hit) begin
            idx_next   = dec_idx;
            adr_next   = SUB_BASE[dec_idx] ? (m_adr - SLAVE_BASE[dec_idx]) : m_adr;
            sel_next   = m_sel;
            we_next    = m_we;
            wdat_next  = m_dat_i;
            cnt_next   = '0;
            state_next = BUSY;
          end else begin
            rdat_next  = '0;
            state_next = ERR;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // Abort outranks everything; ack outranks both error sources.
        if (!m_cyc) begin
          state_next = IDLE;
        end else if (s_ack[idx_reg]) begin
          rdat_next  = s_rdat[idx_reg];
          state_next = RESP_ACK;
        end else if (s_err[idx_reg]) begin
          rdat_next  = '0;
          state_next = RESP_ERR;
        end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
          rdat_next  = '0;
          state_next = RESP_ERR;
        end
      end
      RESP_ACK, RESP_ERR, ERR: state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      adr_reg   <= adr_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      wdat_reg  <= wdat_next;
      rdat_reg  <= rdat_next;
    end
  end

  // Strobes and responses decode straight from registered state, so an
  // asynchronous reset clears them without waiting for a clock.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_strobe
      assign s_cyc[gi] = (state_reg == BUSY) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign s_stb   = s_cyc;
  assign s_we    = we_reg;
  assign s_adr   = adr_reg;
  assign s_sel   = sel_reg;
  assign s_dat_o = wdat_reg;
  assign m_dat_o = rdat_reg;
  assign m_ack   = (state_reg == RESP_ACK);
  assign m_err   = (state_reg == RESP_ERR) || (state_reg == ERR);

endmodule
